// File: rtl/cache_burst_controller_pkg.sv
// Shared types and defaults for the burst cache controller.
// The Hit_Cnt/Miss_Cnt feature is enabled by defining CACHE_PERF_CNT_EN.
package cache_burst_controller_pkg;

  localparam int unsigned DEF_WORDS  = 4;
  localparam int unsigned DEF_WSEL_W = 2;
  localparam int unsigned DEF_BYTES  = 4;
  localparam int unsigned DEF_CNT_W  = 32;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_TAG  = 2'd1,
    ST_MB   = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Word index to one-hot word enable at the default block size
  function automatic logic [DEF_WORDS-1:0] onehot(input logic [DEF_WSEL_W-1:0] sel);
    return DEF_WORDS'(1) << sel;
  endfunction

endpackage

// File: rtl/cache_burst_controller_if.sv
// CPU, tag/data array and memory-side signals of the burst cache controller.
// Hit_Cnt/Miss_Cnt exist only when CACHE_PERF_CNT_EN is defined.
interface cache_burst_controller_if
  import cache_burst_controller_pkg::*;
#(
  parameter int unsigned WORDS  = DEF_WORDS,
  parameter int unsigned WSEL_W = DEF_WSEL_W,
`ifdef CACHE_PERF_CNT_EN
  parameter int unsigned CNT_W  = DEF_CNT_W,
`endif
  parameter int unsigned BYTES  = DEF_BYTES
);
  logic              Req_CPU;
  logic              Wr_CPU;
  logic [BYTES-1:0]  Be_CPU;
  logic [WSEL_W-1:0] Word_Select;
  logic              Hit;
  logic              Dirty;
  logic              Rdy_Low;
  logic              Rdy_CPU;
  logic              Req_Low;
  logic              Wr_Low;
  logic [WSEL_W-1:0] Beat_Low;
  logic              ASel;
  logic [WORDS-1:0]  Wn;
  logic [WORDS-1:0]  En_Word;
  logic [BYTES-1:0]  En_Byte;
  logic              Wr;
  logic              ValidNew;
  logic              DirtyNew;
`ifdef CACHE_PERF_CNT_EN
  logic [CNT_W-1:0]  Hit_Cnt;
  logic [CNT_W-1:0]  Miss_Cnt;
`endif

  modport master (
    output Req_CPU, Wr_CPU, Be_CPU, Word_Select, Hit, Dirty, Rdy_Low,
`ifdef CACHE_PERF_CNT_EN
    input  Hit_Cnt, Miss_Cnt,
`endif
    input  Rdy_CPU, Req_Low, Wr_Low, Beat_Low, ASel, Wn, En_Word, En_Byte,
           Wr, ValidNew, DirtyNew
  );

  modport slave (
    input  Req_CPU, Wr_CPU, Be_CPU, Word_Select, Hit, Dirty, Rdy_Low,
`ifdef CACHE_PERF_CNT_EN
    output Hit_Cnt, Miss_Cnt,
`endif
    output Rdy_CPU, Req_Low, Wr_Low, Beat_Low, ASel, Wn, En_Word, En_Byte,
           Wr, ValidNew, DirtyNew
  );

endinterface

// File: rtl/cache_burst_controller_beat_counter.sv
// Beat index shared by write-back and refill bursts; wraps naturally after the last beat.
module cache_burst_controller_beat_counter #(
  parameter int unsigned WORDS  = 4,
  parameter int unsigned WSEL_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_inc,
  input  logic              i_clear,
  output logic [WSEL_W-1:0] o_beat,
  output logic              o_last
);
  logic [WSEL_W-1:0] r_beat;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_beat <= '0;
    end else if (i_clear) begin
      r_beat <= '0;
    end else if (i_inc) begin
      r_beat <= r_beat + WSEL_W'(1);
    end
  end

  assign o_beat = r_beat;
  assign o_last = (r_beat == WSEL_W'(WORDS - 1));

endmodule

// File: rtl/cache_burst_controller.sv
// Write-back, write-allocate direct-mapped cache controller with beat-per-word memory bursts.
// Define CACHE_PERF_CNT_EN to add saturating hit/miss counters.
module cache_burst_controller
  import cache_burst_controller_pkg::*;
#(
  parameter int unsigned WORDS  = DEF_WORDS,
  parameter int unsigned WSEL_W = DEF_WSEL_W,
`ifdef CACHE_PERF_CNT_EN
  parameter int unsigned CNT_W  = DEF_CNT_W,
`endif
  parameter int unsigned BYTES  = DEF_BYTES
) (
  input logic                     clk,
  input logic                     rst,
  cache_burst_controller_if.slave bus
);
  state_t            r_state;
  state_t            w_next;
  logic              w_inc;
  logic              w_clear;
  logic [WSEL_W-1:0] w_beat;
  logic              w_last;

  logic              w_rdy_cpu;
  logic              w_req_low;
  logic              w_wr_low;
  logic [WSEL_W-1:0] w_beat_low;
  logic              w_asel;
  logic [WORDS-1:0]  w_wn;
  logic [WORDS-1:0]  w_en_word;
  logic [BYTES-1:0]  w_en_byte;
  logic              w_wr;
  logic              w_valid_new;
  logic              w_dirty_new;

  cache_burst_controller_beat_counter #(
    .WORDS  (WORDS),
    .WSEL_W (WSEL_W)
  ) u_beat (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_inc),
    .i_clear (w_clear),
    .o_beat  (w_beat),
    .o_last  (w_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and state-decoded array/memory controls
  always_comb begin
    w_next      = r_state;
    w_inc       = 1'b0;
    w_clear     = 1'b0;
    w_rdy_cpu   = 1'b0;
    w_req_low   = 1'b0;
    w_wr_low    = 1'b0;
    w_beat_low  = '0;
    w_asel      = 1'b0;
    w_wn        = '0;
    w_en_word   = '0;
    w_en_byte   = '0;
    w_wr        = 1'b0;
    w_valid_new = 1'b0;
    w_dirty_new = 1'b0;
    unique case (r_state)
      ST_INIT: begin
        w_clear = 1'b1;
        w_next  = ST_TAG;
      end
      ST_TAG: begin
        w_rdy_cpu = bus.Req_CPU && bus.Hit;
        if (bus.Req_CPU && bus.Hit && bus.Wr_CPU) begin
          w_wr        = 1'b1;
          w_en_word   = WORDS'(1) << bus.Word_Select;
          w_en_byte   = bus.Be_CPU;
          w_valid_new = 1'b1;
          w_dirty_new = 1'b1;
        end
        if (bus.Req_CPU && !bus.Hit) begin
          w_next = bus.Dirty ? ST_WB : ST_MB;
        end
      end
      ST_WB: begin
        w_req_low  = 1'b1;
        w_wr_low   = 1'b1;
        w_asel     = 1'b1;
        w_beat_low = w_beat;
        if (bus.Rdy_Low) begin
          w_inc = 1'b1;
          if (w_last) begin
            w_next = ST_MB;
          end
        end
      end
      ST_MB: begin
        w_req_low  = 1'b1;
        w_beat_low = w_beat;
        if (bus.Rdy_Low) begin
          w_wr        = 1'b1;
          w_en_word   = WORDS'(1) << w_beat;
          w_en_byte   = '1;
          w_wn        = '1;
          w_valid_new = w_last;
          w_inc       = 1'b1;
          if (w_last) begin
            w_next = ST_TAG;
          end
        end
      end
      default: w_next = ST_INIT;
    endcase
  end

  assign bus.Rdy_CPU  = w_rdy_cpu;
  assign bus.Req_Low  = w_req_low;
  assign bus.Wr_Low   = w_wr_low;
  assign bus.Beat_Low = w_beat_low;
  assign bus.ASel     = w_asel;
  assign bus.Wn       = w_wn;
  assign bus.En_Word  = w_en_word;
  assign bus.En_Byte  = w_en_byte;
  assign bus.Wr       = w_wr;
  assign bus.ValidNew = w_valid_new;
  assign bus.DirtyNew = w_dirty_new;

`ifdef CACHE_PERF_CNT_EN
  logic             r_replay;
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  // Replayed access after a refill is not counted as a hit
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_replay   <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (r_state == ST_TAG) begin
        r_replay <= 1'b0;
      end else if (r_state == ST_MB && bus.Rdy_Low && w_last) begin
        r_replay <= 1'b1;
      end
      if (r_state == ST_TAG && bus.Req_CPU && bus.Hit && !r_replay && (r_hit_cnt != '1)) begin
        r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      end
      if (r_state == ST_TAG && bus.Req_CPU && !bus.Hit && (r_miss_cnt != '1)) begin
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.Hit_Cnt  = r_hit_cnt;
  assign bus.Miss_Cnt = r_miss_cnt;
`endif

endmodule
